// File: rtl/score_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : score_uart_tx
// Description : Collects N_SCORES 32-bit class scores, tracks the running
//               argmax, and on receipt of the last class index serializes a
//               frame (header, argmax, all scores MSB first, XOR checksum)
//               one byte at a time to a UART transmitter using a
//               start/ready handshake.
// Ports       : clk, rst           - clock, asynchronous active-high reset
//               score_valid        - score_data/score_idx valid this cycle
//               score_data [31:0]  - class score (unsigned)
//               score_idx  [IDX_W] - class index of score_data
//               tx_ordy            - UART transmitter idle/ready
//               tx_start           - one-cycle byte-launch pulse
//               tx_data [7:0]      - byte to transmit
//               digit [3:0]        - argmax of last completed frame
//               busy               - frame serialization in progress
//               overrun            - sticky: score arrived while busy
// Revision    : 1.0 - initial release
// ============================================================================
module score_uart_tx #(
  parameter int          N_SCORES = 10,
  parameter int          IDX_W    = 10,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             score_valid,
  input  logic [31:0]      score_data,
  input  logic [IDX_W-1:0] score_idx,
  input  logic             tx_ordy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [3:0]       digit,
  output logic             busy,
  output logic             overrun
);

  // Frame length: header + argmax + 4 bytes per score + checksum.
  localparam int          c_nbytes = 3 + 4 * N_SCORES;
  localparam logic [6:0]  c_last   = 7'(c_nbytes - 1);
  localparam logic [31:0] c_n      = 32'(N_SCORES);
  localparam logic [31:0] c_top    = 32'(N_SCORES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_buf [N_SCORES];
  logic [31:0] r_max;
  logic [3:0]  r_arg;
  logic        r_first;   // next accepted score loads max/argmax unconditionally
  logic [6:0]  r_cnt;
  logic [7:0]  r_chk;

  logic [31:0] w_idx_ext;
  logic        w_accept;
  logic        w_last_idx;
  logic        w_take;
  logic [3:0]  w_arg_next;
  logic [6:0]  w_off;
  logic [31:0] w_word;
  logic [7:0]  w_byte;

  assign w_idx_ext  = 32'(score_idx);
  // Out-of-range indices are dropped entirely, including frame completion.
  assign w_accept   = score_valid && (w_idx_ext < c_n) && (r_state == ST_IDLE);
  assign w_last_idx = (w_idx_ext == c_top);
  // Strictly greater keeps the earliest arrival on ties.
  assign w_take     = r_first || (score_data > r_max);
  assign w_arg_next = w_take ? w_idx_ext[3:0] : r_arg;

  // Byte selector for the current frame position. Score bytes start at
  // position 2; word index is offset/4, byte lane is offset%4 (MSB first).
  always_comb begin
    w_off  = r_cnt - 7'd2;
    w_word = 32'd0;
    for (int i = 0; i < N_SCORES; i++) begin
      if (w_off[6:2] == i[4:0]) begin
        w_word = r_buf[i];
      end
    end
    w_byte = 8'd0;
    if (r_cnt == 7'd0) begin
      w_byte = HEADER;
    end else if (r_cnt == 7'd1) begin
      w_byte = {4'b0000, digit};
    end else if (r_cnt == c_last) begin
      w_byte = r_chk;
    end else begin
      case (w_off[1:0])
        2'd0:    w_byte = w_word[31:24];
        2'd1:    w_byte = w_word[23:16];
        2'd2:    w_byte = w_word[15:8];
        default: w_byte = w_word[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'd0;
      digit    <= 4'd0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      r_max    <= 32'd0;
      r_arg    <= 4'd0;
      r_first  <= 1'b1;
      r_cnt    <= 7'd0;
      r_chk    <= 8'd0;
      for (int i = 0; i < N_SCORES; i++) begin
        r_buf[i] <= 32'd0;
      end
    end else begin
      tx_start <= 1'b0;

      // Scores offered mid-frame are flagged and otherwise discarded.
      if (score_valid && busy) begin
        overrun <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            for (int i = 0; i < N_SCORES; i++) begin
              if (w_idx_ext[3:0] == i[3:0]) begin
                r_buf[i] <= score_data;
              end
            end
            if (w_take) begin
              r_max <= score_data;
            end
            r_arg   <= w_arg_next;
            r_first <= 1'b0;
            if (w_last_idx) begin
              digit   <= w_arg_next;
              busy    <= 1'b1;
              r_cnt   <= 7'd0;
              r_chk   <= 8'd0;
              r_first <= 1'b1;
              r_state <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          tx_data <= w_byte;
          if (r_cnt != c_last) begin
            r_chk <= r_chk ^ w_byte;
          end
          r_state <= ST_SEND;
        end

        ST_SEND: begin
          if (tx_ordy) begin
            tx_start <= 1'b1;
            r_state  <= ST_WAIT_BUSY;
          end
        end

        // Wait for the transmitter to acknowledge the launch by dropping ready.
        ST_WAIT_BUSY: begin
          if (!tx_ordy) begin
            r_state <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          if (tx_ordy) begin
            if (r_cnt == c_last) begin
              busy    <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt   <= r_cnt + 7'd1;
              r_state <= ST_LOAD;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
